// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester round-robin binary-to-Gray converter
//
// Purpose:
//   Two requesters share one binary-to-Gray datapath. A round-robin arbiter
//   picks one word per cycle. The Gray result and its source index are
//   registered and held until the consumer takes them.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req0_valid/bin/ready    requester 0 handshake and binary word
//   req1_valid/bin/ready    requester 1 handshake and binary word
//   out_valid/gray/src      held result, its Gray code and requester index
//   out_ready               consumer accepts the held result
//   conv_count              accepted-request counter (wraps)
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_bin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_bin,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_gray;
  logic             r_src;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_count;

  logic             w_can_accept;
  logic             w_grant_vld;
  logic             w_grant_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_bin;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  // Pass-through drain: a held result leaving this cycle frees the register
  // for a new word in the same cycle.
  assign w_can_accept = (r_state == S_EMPTY) || out_ready;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_idx = ~r_last_grant;
    end else if (req0_valid) begin
      w_grant_vld = 1'b1;
      w_grant_idx = 1'b0;
    end else if (req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_idx = 1'b1;
    end
  end

  assign w_accept   = w_grant_vld && w_can_accept;
  assign req0_ready = w_accept && (w_grant_idx == 1'b0);
  assign req1_ready = w_accept && (w_grant_idx == 1'b1);
  assign w_sel_bin  = w_grant_idx ? req1_bin : req0_bin;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (w_accept)       w_state_nxt = S_FULL;
        else if (out_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_gray       <= '0;
      r_src        <= 1'b0;
      r_last_grant <= 1'b1;  // requester 0 wins the first contention
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Priority only rotates on acceptance, never on idle cycles.
      if (w_accept) begin
        r_gray       <= bin2gray(w_sel_bin);
        r_src        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_count      <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_valid  = (r_state == S_FULL);
  assign out_gray   = r_gray;
  assign out_src    = r_src;
  assign conv_count = r_count;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - scoreboard bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_bin, req1_bin;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_gray;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] conv_count;

  gray_conv_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_bin   (req0_bin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_bin   (req1_bin),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_gray   (out_gray),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] gray_ref(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard entries: {src, gray}
  logic [WIDTH:0]   sb_q[$];
  logic             m_full  = 1'b0;
  logic             m_last  = 1'b1;
  logic [CNT_W-1:0] m_count = '0;
  logic             hold0   = 1'b0;
  logic             hold1   = 1'b0;
  logic             sweep_on = 1'b0;
  logic             have_prev = 1'b0;
  logic [WIDTH-1:0] prev_gray = '0;

  // Reference model, evaluated mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    logic       e0, e1, can, both;
    logic [WIDTH:0] ent;
    if (!rst_n) begin
      sb_q.delete();
      m_full  = 1'b0;
      m_last  = 1'b1;
      m_count = '0;
      hold0   = 1'b0;
      hold1   = 1'b0;
    end else begin
      chk("out_valid", out_valid, m_full);
      chk("conv_count", conv_count, m_count);
      can = !m_full || out_ready;
      if (m_full && sb_q.size() > 0) begin
        ent = sb_q[0];
        chk("out_gray", out_gray, ent[WIDTH-1:0]);
        chk("out_src", out_src, ent[WIDTH]);
        if (out_ready) begin
          void'(sb_q.pop_front());
          if (sweep_on) begin
            if (have_prev) chk("gray_one_bit_step", $countones(prev_gray ^ out_gray), 1);
            prev_gray = out_gray;
            have_prev = 1'b1;
          end
        end
      end
      both = req0_valid && req1_valid;
      e0 = can && req0_valid && (!req1_valid || (both && m_last == 1'b1));
      e1 = can && req1_valid && (!req0_valid || (both && m_last == 1'b0));
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      if (e0) begin
        sb_q.push_back({1'b0, gray_ref(req0_bin)});
        m_last = 1'b0;
        m_count++;
      end
      if (e1) begin
        sb_q.push_back({1'b1, gray_ref(req1_bin)});
        m_last = 1'b1;
        m_count++;
      end
      m_full = e0 || e1 || (m_full && !out_ready);
      hold0  = req0_valid && !e0;
      hold1  = req1_valid && !e1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bin = '0; req1_bin = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_conv_count", conv_count, 0);

    // Single request from requester 0
    req0_valid = 1'b1; req0_bin = 4'b0110; out_ready = 1'b1;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_gray", out_gray, 4'b0101);
    chk("t1_out_src", out_src, 0);
    chk("t1_conv_count", conv_count, 1);

    // Contention with full throughput
    req0_valid = 1'b1; req0_bin = 4'b0011;
    req1_valid = 1'b1; req1_bin = 4'b1000;
    repeat (8) step();

    // Backpressure while both keep requesting
    out_ready = 1'b0;
    repeat (6) step();
    out_ready = 1'b1;
    repeat (4) step();

    // Sweep on requester 1, ending with the 15 -> 0 wrap
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
    have_prev = 1'b0;
    sweep_on  = 1'b1;
    req1_valid = 1'b1;
    for (int b = 0; b <= 16; b++) begin
      req1_bin = 4'(b);
      step();
    end
    req1_valid = 1'b0;
    step(); step();
    sweep_on = 1'b0;

    // Reset while a result is held
    req0_valid = 1'b1; req0_bin = 4'b1010; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_conv_count", conv_count, 0);
    req0_valid = 1'b1; req0_bin = 4'b0001;
    req1_valid = 1'b1; req1_bin = 4'b1110; out_ready = 1'b1;
    #1;
    chk("rst2_grant_req0", req0_ready, 1);
    chk("rst2_loser_req1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();

    // Counter wrap after 256 acceptances
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_bin = 4'b0111; out_ready = 1'b1;
    repeat (128) step();
    chk("wrap_half", conv_count, 128);
    repeat (128) step();
    chk("wrap_count", conv_count, 0);
    req0_valid = 1'b0;
    step(); step();

    // Random traffic honouring the hold-until-ready rule
    for (int c = 0; c < 300; c++) begin
      if (!hold0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_bin   = 4'($urandom_range(0, 15));
      end
      if (!hold1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_bin   = 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
